mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single external memory port between two requesters: the instruction-fetch side, which feeds the controller's i_odv, and the data side (load/store stage), which feeds d_odv.
- Serialises the two requesters, drives the memory handshake, and returns one-cycle output-data-valid strobes to each requester.
- Data side has fixed priority, with a starvation guard for fetch and a memory-timeout abort so the controller can never hang in a wait state.

Parameters:
- ADDR_W, 16, address width for both requesters and the memory port.
- DATA_W, 32, data width.
- STARVE_MAX, 4, number of consecutive data grants allowed while i_req is pending; the next grant is forced to fetch.
- TIMEOUT, 64, number of mem_en cycles without mem_rdy before the access is aborted.

Ports:
- g_clk  in  1  system clock, rising edge.
- g_clr  in  1  synchronous reset, active-low.
- i_req  in  1  fetch request; level signal, held until i_odv.
- i_addr  in  ADDR_W  fetch address, stable while i_req is high.
- d_req  in  1  data request; level signal, held until d_odv.
- d_we  in  1  1 = store, 0 = load; stable while d_req is high.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- mem_en  out  1  memory access strobe; held until mem_rdy.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid when mem_rdy is high.
- mem_rdy  in  1  memory completion.
- i_odv  out  1  one-cycle fetch completion strobe.
- i_data  out  DATA_W  fetched word; valid with i_odv.
- d_odv  out  1  one-cycle data completion strobe (loads and stores).
- d_data  out  DATA_W  load result; valid with d_odv.
- busy  out  1  high in any state other than IDLE.
- err_timeout  out  1  sticky flag, set on an aborted access.

Behaviour:
- Reset (g_clr == 0 at a rising edge) forces:
  - all outputs to 0 and the FSM to IDLE;
  - starve_cnt and tmo_cnt to 0.
- Reset mid-access: any access in flight is abandoned, no odv is issued, and mem_en drops the next cycle.
- FSM states: IDLE, I_ACC, D_ACC, RESP.
- IDLE, grant decision:
  - d_req && !(i_req && starve_cnt == STARVE_MAX) -> D_ACC;
  - else i_req -> I_ACC;
  - else stay in IDLE.
- On entering an ACC state: latch the address, we and wdata into the mem_* output registers, set mem_en = 1, clear tmo_cnt.
  - mem_we = d_we in D_ACC; mem_we = 0 in I_ACC.
- starve_cnt rules (updated on the IDLE grant decision):
  - increments on a data grant while i_req is high, saturating at STARVE_MAX;
  - clears on any fetch grant;
  - clears on a data grant while i_req is low.
- ACC states:
  - mem_en stays high and tmo_cnt increments each cycle;
  - mem_rdy == 1 -> capture mem_rdata into i_data or d_data, drop mem_en, go to RESP;
  - tmo_cnt == TIMEOUT-1 with no mem_rdy -> drop mem_en, set err_timeout, force the data register to 0, go to RESP.
- RESP:
  - assert i_odv or d_odv for exactly one cycle, matching the granted side, then return to IDLE;
  - i_data and d_data hold their value until the next completion on the same side.
- Latency:
  - request high in IDLE at cycle n -> mem_en at n+1;
  - mem_rdy at cycle m -> odv at m+1;
  - with zero-wait memory (mem_rdy at n+1), odv is at n+2.
- Back-to-back throughput: the earliest regrant is the cycle after RESP, i.e. one access per 3 cycles.
- Requesters must drop req in the cycle after odv. A req still high in the IDLE cycle after its odv is treated as a new request.
- Simultaneous i_req and d_req in IDLE: data wins unless the starvation guard has fired.
- err_timeout clears only on reset.
- mem_rdy outside the ACC states is ignored.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_I_ACC=2'd1, ST_D_ACC=2'd2, ST_RESP=2'd3;
  - a grant-owner constant (OWN_I/OWN_D).
- One natural sub-module: arb_timeout_cnt, a loadable up-counter with a terminal-count flag, parameterised by TIMEOUT.
- Grant logic and FSM stay in the top module.

Test Plan:
- Lone fetch: i_req=1, i_addr=16'h0040, mem_rdy one cycle after mem_en, mem_rdata=32'hDEADBEEF -> mem_en at n+1 with mem_addr=16'h0040 and mem_we=0; i_odv at n+3 with i_data=32'hDEADBEEF; d_odv never asserts.
- Store: d_req=1, d_we=1, d_addr=16'h0100, d_wdata=32'h12345678 -> mem_we=1, mem_wdata=32'h12345678; d_odv pulses once; err_timeout stays 0.
- Contention: i_req and d_req held continuously, zero-wait memory -> grant order D,D,D,D,I,D,D,D,D,I; exactly one mem_en access per odv.
- Timeout: d_req=1, d_we=0, mem_rdy tied 0 -> mem_en high for exactly 64 cycles, then d_odv with d_data=0; err_timeout=1 and stays 1 through two further accesses.
- Mid-access reset: g_clr=0 while in D_ACC -> next cycle mem_en=0, busy=0, no d_odv; a fresh i_req afterwards is granted normally.
- Wait-state memory: mem_rdy delayed 5 cycles on a fetch -> mem_addr stable for all 5 cycles; i_odv exactly one cycle, one cycle after mem_rdy.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encoding and grant owner.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_I_ACC = 2'd1,
    ST_D_ACC = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_timeout_cnt.sv
// Loadable up-counter for the memory wait timeout; tc flags the last allowed wait cycle.
module arb_timeout_cnt #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic clr_n,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!clr_n)
      cnt <= '0;
    else if (load)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data requesters onto one memory port with fixed data
// priority, a fetch starvation guard and a memory timeout abort.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              g_clk,
  input  logic              g_clr,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic              i_odv,
  output logic [DATA_W-1:0] i_data,
  output logic              d_odv,
  output logic [DATA_W-1:0] d_data,
  output logic              busy,
  output logic              err_timeout,
  output logic [1:0]        dbg_state
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  // Handshake: i_req/d_req are levels held until the matching one-cycle odv;
  // mem_en is held with stable address/data until mem_rdy or timeout.
  arb_state_t    state;
  logic          owner;
  logic [SW-1:0] starve_cnt;
  logic          starve_hit;
  logic          grant_d;
  logic          grant_i;
  logic          in_acc;
  logic          tmo_load;
  logic          tmo_tc;

  assign starve_hit = i_req && (starve_cnt == SW'(STARVE_MAX));
  assign grant_d    = d_req && !starve_hit;
  assign grant_i    = i_req && !grant_d;
  assign in_acc     = (state == ST_I_ACC) || (state == ST_D_ACC);
  assign tmo_load   = (state == ST_IDLE) && (grant_d || grant_i);
  assign dbg_state  = state;

  arb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk   (g_clk),
    .clr_n (g_clr),
    .load  (tmo_load),
    .en    (in_acc),
    .tc    (tmo_tc)
  );

  always_ff @(posedge g_clk) begin
    if (!g_clr) begin
      state       <= ST_IDLE;
      owner       <= OWN_I;
      starve_cnt  <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      i_odv       <= 1'b0;
      i_data      <= '0;
      d_odv       <= 1'b0;
      d_data      <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      i_odv <= 1'b0;
      d_odv <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_d) begin
            state     <= ST_D_ACC;
            owner     <= OWN_D;
            mem_en    <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            busy      <= 1'b1;
            if (!i_req)
              starve_cnt <= '0;
            else if (starve_cnt != SW'(STARVE_MAX))
              starve_cnt <= starve_cnt + 1'b1;
          end else if (grant_i) begin
            state      <= ST_I_ACC;
            owner      <= OWN_I;
            mem_en     <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= i_addr;
            busy       <= 1'b1;
            starve_cnt <= '0;
          end
        end
        ST_I_ACC, ST_D_ACC: begin
          if (mem_rdy || tmo_tc) begin
            state  <= ST_RESP;
            mem_en <= 1'b0;
            // An aborted access returns zero so the requester never sees stale data.
            if (owner == OWN_D) begin
              d_data <= mem_rdy ? mem_rdata : '0;
              d_odv  <= 1'b1;
            end else begin
              i_data <= mem_rdy ? mem_rdata : '0;
              i_odv  <= 1'b1;
            end
            if (!mem_rdy)
              err_timeout <= 1'b1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
